// File: rtl/sonar_pkg.sv
// Shared state encodings, frame character constants and frame geometry
// for the sonar sweep controller.
package sonar_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    POSICIONA = 4'd1,
    MEDE      = 4'd2,
    TX_LOAD   = 4'd3,
    TX_WAIT   = 4'd4,
    PROXIMO   = 4'd5
  } state_e;

  localparam logic [6:0] SEP        = 7'h2C;
  localparam logic [6:0] TERM       = 7'h23;
  localparam logic [6:0] INVALID    = 7'h3F;
  localparam logic [6:0] ASCII_ZERO = 7'h30;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  // Distance reported when a measurement never completes.
  localparam logic [11:0] TIMEOUT_DIST = 12'h999;

endpackage

// File: rtl/sonar_frame_mux.sv
// Maps a frame character index plus the latched BCD angle/distance to the
// 7-bit ASCII character to transmit; non-decimal nibbles become '?'.
module sonar_frame_mux
  import sonar_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic [11:0]      ang_i,
  input  logic [11:0]      dist_i,
  output logic [6:0]       char_o
);

  function automatic logic [6:0] digit_char(input logic [3:0] nib);
    if (nib > 4'd9) return INVALID;
    return ASCII_ZERO + {3'b000, nib};
  endfunction

  always_comb begin
    char_o = TERM;
    case (idx_i)
      3'd0:    char_o = digit_char(ang_i[11:8]);
      3'd1:    char_o = digit_char(ang_i[7:4]);
      3'd2:    char_o = digit_char(ang_i[3:0]);
      3'd3:    char_o = SEP;
      3'd4:    char_o = digit_char(dist_i[11:8]);
      3'd5:    char_o = digit_char(dist_i[7:4]);
      3'd6:    char_o = digit_char(dist_i[3:0]);
      default: char_o = TERM;
    endcase
  end

endmodule

// File: rtl/sonar_sweep_ctrl.sv
// Servo sweep sequencer: settle, trigger one HC-SR04 measurement, stream an
// 8-char ASCII frame. Optional measurement watchdog: define SONAR_TIMEOUT_EN.
module sonar_sweep_ctrl
  import sonar_pkg::*;
#(
  parameter int N_POS      = 8,
  parameter int POS_W      = 3,
  parameter int T_INTERVAL = 50_000_000,
  parameter int T_TIMEOUT  = 1_500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  input  logic             pausa,
  input  logic [11:0]      angulo,
  input  logic [11:0]      medida,
  input  logic             medida_pronto,
  input  logic             tx_pronto,
  output logic [POS_W-1:0] posicao,
  output logic             medir,
  output logic             partida,
  output logic [6:0]       dados_ascii,
  output logic             varredura_fim,
  output logic             erro,
  output logic [3:0]       db_estado
);

  localparam int               CNT_W    = $clog2(T_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_INTERVAL - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_POS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  if (N_POS < 1 || (2 ** POS_W) < N_POS || T_INTERVAL < 1 || T_TIMEOUT < 1) begin : g_param_check
    $error("sonar_sweep_ctrl: invalid parameter set");
  end

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;     // 1 = stepping up
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             medir_q, medir_d;
  logic             vfim_q, vfim_d;
  logic             latch_frame;
  logic             timeout;
  logic [11:0]      ang_q, dist_q;
  logic [6:0]       frame_char;

`ifdef SONAR_TIMEOUT_EN
  localparam int              WD_W    = $clog2(T_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(T_TIMEOUT - 1);

  logic [WD_W-1:0] wd_q;
  logic            erro_q;

  // A pronto arriving on the expiry cycle still counts as a valid measurement.
  assign timeout = (state_q == MEDE) && !medida_pronto && (wd_q == WD_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_q   <= '0;
      erro_q <= 1'b0;
    end else begin
      wd_q <= (state_q == MEDE) ? wd_q + 1'b1 : '0;
      if (state_q == IDLE && ligar) erro_q <= 1'b0;
      else if (timeout)             erro_q <= 1'b1;
    end
  end

  assign erro = erro_q;
`else
  assign timeout = 1'b0;
  assign erro    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    medir_d     = 1'b0;
    vfim_d      = 1'b0;
    latch_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (ligar) begin
          state_d = POSICIONA;
          pos_d   = '0;
          dir_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      POSICIONA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          medir_d = 1'b1;
          state_d = MEDE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEDE: begin
        if (medida_pronto || timeout) begin
          latch_frame = 1'b1;
          idx_d       = '0;
          state_d     = TX_LOAD;
        end
      end
      TX_LOAD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_pronto) begin
          if (idx_q == IDX_LAST) begin
            state_d = PROXIMO;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = TX_LOAD;
          end
        end
      end
      PROXIMO: begin
        if (!ligar) begin
          state_d = IDLE;
        end else if (pausa) begin
          state_d = PROXIMO;
        end else if (modo && pos_q == LAST_POS) begin
          vfim_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = POSICIONA;
          // Endpoints are left in the opposite direction, so each is visited once per turn.
          if (N_POS > 1) begin
            if (dir_q) begin
              if (pos_q == LAST_POS) begin
                pos_d = pos_q - 1'b1;
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = pos_q + 1'b1;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      medir_q <= 1'b0;
      vfim_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      medir_q <= medir_d;
      vfim_q  <= vfim_d;
    end
  end

  always_ff @(posedge clock) begin
    if (latch_frame) begin
      ang_q  <= angulo;
      dist_q <= medida_pronto ? medida : TIMEOUT_DIST;
    end
  end

  sonar_frame_mux u_frame_mux (
    .idx_i  (idx_q),
    .ang_i  (ang_q),
    .dist_i (dist_q),
    .char_o (frame_char)
  );

  assign posicao       = pos_q;
  assign medir         = medir_q;
  assign partida       = (state_q == TX_LOAD);
  assign dados_ascii   = (state_q == TX_LOAD || state_q == TX_WAIT) ? frame_char : 7'h00;
  assign varredura_fim = vfim_q;
  assign db_estado     = state_q;

endmodule

// File: tb/tb_sonar_sweep_ctrl.sv
// Directed bench for sonar_sweep_ctrl (N_POS=4, T_INTERVAL=10, T_TIMEOUT=50);
// watchdog cases run only when SONAR_TIMEOUT_EN is defined.
module tb_sonar_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset, ligar, modo, pausa, medida_pronto, tx_pronto;
  logic [11:0] angulo, medida;
  logic [2:0]  posicao;
  logic        medir, partida, varredura_fim, erro;
  logic [6:0]  dados_ascii;
  logic [3:0]  db_estado;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] F_NORM = 64'h30_34_35_2C_31_32_33_23;
  localparam logic [63:0] F_A7   = 64'h30_34_35_2C_30_3F_37_23;
  localparam logic [63:0] F_999  = 64'h30_34_35_2C_39_39_39_23;

  sonar_sweep_ctrl #(
    .N_POS(4), .POS_W(3), .T_INTERVAL(10), .T_TIMEOUT(50)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .modo(modo), .pausa(pausa),
    .angulo(angulo), .medida(medida), .medida_pronto(medida_pronto),
    .tx_pronto(tx_pronto), .posicao(posicao), .medir(medir), .partida(partida),
    .dados_ascii(dados_ascii), .varredura_fim(varredura_fim), .erro(erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_medir(input int exp_pos);
    int k = 0;
    while (!medir && k < 40) begin tick(); k++; end
    check("medir_seen", 32'(medir), 1);
    check("posicao", 32'(posicao), exp_pos);
    tick();
    check("medir_1cyc", 32'(medir), 0);
  endtask

  task automatic echo();
    repeat (4) tick();
    medida_pronto = 1'b1;
    tick();
    medida_pronto = 1'b0;
  endtask

  task automatic tx_chars(input logic [63:0] frame, input int n_chars);
    logic [6:0] exp_c;
    for (int i = 0; i < n_chars; i++) begin
      int k = 0;
      exp_c = frame[8*(7-i) +: 7];
      while (!partida && k < 20) begin tick(); k++; end
      check("partida", 32'(partida), 1);
      check("char", 32'(dados_ascii), 32'(exp_c));
      tick();
      check("partida_1cyc", 32'(partida), 0);
      tick();
      check("char_hold", 32'(dados_ascii), 32'(exp_c));
      tx_pronto = 1'b1;
      tick();
      tx_pronto = 1'b0;
    end
  endtask

  initial begin
    int pos_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int stray;

    reset = 1'b0; ligar = 1'b0; modo = 1'b0; pausa = 1'b0;
    medida_pronto = 1'b0; tx_pronto = 1'b0;
    angulo = 12'h045; medida = 12'h123;
    repeat (2) tick();
    check("rst_estado", 32'(db_estado), 0);
    check("rst_posicao", 32'(posicao), 0);
    check("rst_medir", 32'(medir), 0);
    check("rst_partida", 32'(partida), 0);
    check("rst_dados", 32'(dados_ascii), 0);
    check("rst_vfim", 32'(varredura_fim), 0);
    check("rst_erro", 32'(erro), 0);
    reset = 1'b1;
    tick();

    // Continuous ping-pong sweep
    ligar = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_medir(pos_seq[i]);
      echo();
      tx_chars(F_NORM, 8);
      check("proximo", 32'(db_estado), 5);
    end
    ligar = 1'b0;
    tick();
    check("stop_idle", 32'(db_estado), 0);
    check("stop_erro", 32'(erro), 0);

    // Single pass
    modo = 1'b1; ligar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_medir(i);
      echo();
      tx_chars(F_NORM, 8);
    end
    tick();
    check("sp_vfim", 32'(varredura_fim), 1);
    check("sp_idle", 32'(db_estado), 0);
    check("sp_posicao", 32'(posicao), 3);
    ligar = 1'b0;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (medir || varredura_fim) stray++;
    end
    check("sp_no_5th", stray, 0);

    // Pause held at a position boundary
    modo = 1'b0; ligar = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_medir(i);
      echo();
      tx_chars(F_NORM, 8);
    end
    tick();
    check("pa_posiciona", 32'(db_estado), 1);
    pausa = 1'b1;
    wait_medir(2);
    echo();
    tx_chars(F_NORM, 8);
    check("pa_hold_estado", 32'(db_estado), 5);
    repeat (5) tick();
    check("pa_hold_estado2", 32'(db_estado), 5);
    check("pa_hold_pos", 32'(posicao), 2);
    pausa = 1'b0;
    tick();
    check("pa_resume_estado", 32'(db_estado), 1);
    check("pa_resume_pos", 32'(posicao), 3);

    // Reset in the middle of a frame
    wait_medir(3);
    echo();
    tx_chars(F_NORM, 4);
    tick();
    check("mr_txwait", 32'(db_estado), 4);
    check("mr_char4", 32'(dados_ascii), 32'h31);
    reset = 1'b0;
    tick();
    check("mr_estado", 32'(db_estado), 0);
    check("mr_posicao", 32'(posicao), 0);
    check("mr_partida", 32'(partida), 0);
    check("mr_dados", 32'(dados_ascii), 0);
    reset = 1'b1; ligar = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (partida || medir || db_estado != 4'd0) stray++;
    end
    check("mr_no_stray", stray, 0);

    // Non-decimal distance nibble
    medida = 12'h0A7; ligar = 1'b1;
    wait_medir(0);
    echo();
    tx_chars(F_A7, 8);
    ligar = 1'b0;
    medida = 12'h123;
    tick();
    check("bad_idle", 32'(db_estado), 0);

`ifdef SONAR_TIMEOUT_EN
    // Watchdog expiry without an answer
    ligar = 1'b1;
    wait_medir(0);
    repeat (48) tick();
    check("to_mede_c50", 32'(db_estado), 2);
    check("to_erro_c50", 32'(erro), 0);
    tick();
    check("to_txload", 32'(db_estado), 3);
    check("to_erro", 32'(erro), 1);
    tx_chars(F_999, 8);
    ligar = 1'b0;
    tick();
    check("to_sticky", 32'(erro), 1);
    ligar = 1'b1;
    tick();
    check("to_clear", 32'(erro), 0);

    // Answer on the expiry cycle
    wait_medir(0);
    repeat (48) tick();
    medida_pronto = 1'b1;
    tick();
    medida_pronto = 1'b0;
    check("tie_txload", 32'(db_estado), 3);
    check("tie_erro", 32'(erro), 0);
    tx_chars(F_NORM, 8);
    ligar = 1'b0;
    tick();
    check("tie_erro_end", 32'(erro), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sonar_sweep_ctrl.md
Name: sonar_sweep_ctrl

Overview:
- Parametrised successor to the current sonar datapath control path.
- Sequences a servo sweep over N_POS positions (ping-pong or single-pass), waits a settle interval, triggers one HC-SR04 measurement, then streams an 8-character ASCII frame to the serial transmitter.
- Sits between the top-level FSM/buttons and the existing interface_hcsr04, controle_servo_3 and tx_serial_7O1 instances; replaces their external up/down counter, serial counter and mux plumbing.

Parameters:
- N_POS, 8, number of servo positions (≥1).
- POS_W, 3, width of posicao; must satisfy 2^POS_W ≥ N_POS.
- T_INTERVAL, 50_000_000, settle cycles per position before measuring.
- T_TIMEOUT, 1_500_000, measurement watchdog cycles (used only with SONAR_TIMEOUT_EN).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ligar  in  1  level; 1 = run sweep.
- modo  in  1  0 = continuous ping-pong, 1 = single pass 0→N_POS-1.
- pausa  in  1  level; holds the sweep at the next position boundary.
- angulo  in  12  BCD angle for current posicao, from external decoder.
- medida  in  12  BCD distance from interface_hcsr04.
- medida_pronto  in  1  1-cycle measurement-done pulse.
- tx_pronto  in  1  1-cycle character-sent pulse.
- posicao  out  POS_W  current servo position.
- medir  out  1  1-cycle measure request.
- partida  out  1  1-cycle transmit request.
- dados_ascii  out  7  character to send.
- varredura_fim  out  1  1-cycle pulse when a single pass completes.
- erro  out  1  sticky measurement-timeout flag.
- db_estado  out  4  state encoding.

Behaviour:
- Reset (reset=0 at an edge): IDLE, posicao=0, direction=up, all pulses 0, dados_ascii=0, erro=0, counters cleared. Reset has priority in every state, including mid-frame.
- IDLE: if ligar=1, clear erro and go to POSICIONA with posicao=0 and direction=up.
- POSICIONA: count T_INTERVAL cycles, then MEDE. posicao is stable throughout.
- MEDE: assert medir in the first cycle only, then wait for medida_pronto. On the pronto cycle, latch angulo and medida into frame registers and go to TX_LOAD with char index 0.
- Frame, 8 chars, index 0..7: ang_c, ang_d, ang_u, ',' (0x2C), dist_c, dist_d, dist_u, '#' (0x23).
  - Digit char = 0x30 + nibble; a nibble >9 sends '?' (0x3F).
- TX_LOAD: dados_ascii = char[index], partida=1 for one cycle, then TX_WAIT.
- TX_WAIT: hold dados_ascii stable until tx_pronto. On tx_pronto: if index=7 go to PROXIMO, else index+1 and go to TX_LOAD.
- PROXIMO (evaluated in priority order):
  - ligar=0: go to IDLE.
  - pausa=1: stay.
  - modo=1 and posicao=N_POS-1: pulse varredura_fim, go to IDLE.
  - Otherwise step posicao and go to POSICIONA.
- Ping-pong stepping: 0,1,…,N_POS-1,N_POS-2,…,0,1,… Each endpoint is visited once per turn; direction flips on reaching an endpoint.
- N_POS=1: posicao stays 0. In single-pass mode varredura_fim fires after the first frame.
- ligar, pausa and modo are ignored outside IDLE/PROXIMO, so a frame always completes.
- Total latency per position: T_INTERVAL + 1 + echo time + 8 character times + 1 cycle.

Optional Feature:
- Macro SONAR_TIMEOUT_EN.
- Defined: a watchdog counts cycles in MEDE. If T_TIMEOUT elapses without medida_pronto:
  - set erro=1 (sticky until IDLE→run or reset);
  - latch distance as BCD 0x999;
  - proceed to TX_LOAD.
  - If medida_pronto coincides with expiry, pronto wins and erro is not set.
- Not defined: MEDE waits indefinitely; erro tied 0; no watchdog counter is synthesised.

Decomposition:
- Package sonar_pkg holds:
  - state encodings: IDLE=0, POSICIONA=1, MEDE=2, TX_LOAD=3, TX_WAIT=4, PROXIMO=5;
  - character constants: SEP=0x2C, TERM=0x23, INVALID=0x3F, ASCII_ZERO=0x30;
  - FRAME_LEN=8.
- One sub-module, sonar_frame_mux: combinational char index + latched BCD → 7-bit ASCII, including digit validation.
- The FSM, position stepper, interval counter and watchdog stay in the top module.

Test Plan (N_POS=4, T_INTERVAL=10, T_TIMEOUT=50 unless noted):
- ligar=1, modo=0; model answers medir after 5 cycles with medida=0x123, angulo=0x045; tx model acks after 3 cycles → per frame, characters 0x30,0x34,0x35,0x2C,0x31,0x32,0x33,0x23; posicao visits 0,1,2,3,2,1,0,1; medir exactly 1 cycle per position.
- modo=1 single pass → exactly 4 frames, then varredura_fim pulses once and db_estado=0, posicao=3.
- pausa=1 raised during a frame at posicao=2 → frame completes, FSM holds in PROXIMO with posicao=2; pausa=0 → next POSICIONA at posicao=3.
- reset=0 asserted in TX_WAIT at char index 4 → next cycle db_estado=0, posicao=0, partida=0; no stray tx request after release.
- medida=0x0A7 → distance characters 0x30,0x3F,0x37.
- SONAR_TIMEOUT_EN, model never answers → after 50 cycles erro=1 and distance characters 0x39,0x39,0x39; a second run with pronto on exactly cycle 50 → erro stays 0.
